// File: rtl/pdat_rx_pkg.sv
// Shared types and constants for the parallel-data capture receiver.
package pdat_rx_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int SYNC_STAGES = 2;
  localparam int DAT_DLY     = 3;

endpackage

// File: rtl/capture_fifo.sv
// Synchronous sample FIFO with registered read port and a flush input.
module capture_fifo
  import pdat_rx_pkg::*;
#(
  parameter int AW    = 6,
  parameter int W_DAT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [W_DAT-1:0] wd,
  input  logic             re,
  output logic [W_DAT-1:0] rd,
  output logic             rv,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 2**AW;

  logic [W_DAT-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             pop;
  logic             push;

  // Pointers carry one extra wrap bit so a full FIFO is distinguishable from empty.
  assign level = wp - rp;
  assign full  = level[AW];
  assign empty = (level == '0);

  // No read-through when empty; a pop while full frees the slot being written.
  assign pop  = re & ~empty & ~clr;
  assign push = we & (~full | pop) & ~clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      rd <= '0;
      rv <= 1'b0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      rv <= 1'b0;
    end else begin
      rv <= pop;
      if (push) wp <= wp + 1'b1;
      if (pop) begin
        rp <= rp + 1'b1;
        rd <= mem[rp[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= wd;
  end

endmodule

// File: rtl/pdat_capture_rx.sv
// Receive side of the parallel-data link: oversamples ext_clk, captures ext_dat
// on each rising edge and queues the samples for the core.
module pdat_capture_rx
  import pdat_rx_pkg::*;
#(
  parameter int W_DAT = 16,
  parameter int AW    = 6,
  parameter int W_N   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_en,
  input  logic             cap_clr,
  input  logic [W_N-1:0]   n_smp,
  input  logic             ext_clk,
  input  logic [W_DAT-1:0] ext_dat,
  input  logic             rd_en,
  output logic [W_DAT-1:0] rd_dat,
  output logic             rd_vld,
  output logic [AW:0]      level,
  output logic             ovf,
  output logic             done,
  output logic             busy
);

  // state | meaning
  // IDLE  | capture off, FIFO still readable
  // ARMED | waiting for the first edge, which is discarded for alignment
  // RUN   | every edge writes a sample and counts toward n_smp
  // DONE  | n_smp samples taken; no writes until cap_en drops

  state_t           state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             edge_hist;
  logic             edge_q;
  logic [W_DAT-1:0] dat_dly [DAT_DLY];
  logic [W_N-1:0]   cnt;
  logic [W_N-1:0]   cnt_inc;
  logic [W_N-1:0]   n_lat;
  logic             we_q;
  logic [W_DAT-1:0] wd_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;

  // Synchroniser, edge register and matching data delay line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      edge_hist <= 1'b0;
      edge_q    <= 1'b0;
      for (int i = 0; i < DAT_DLY; i++) dat_dly[i] <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], ext_clk};
      edge_hist <= sync_q[SYNC_STAGES-1];
      edge_q    <= sync_q[SYNC_STAGES-1] & ~edge_hist;
      dat_dly[0] <= ext_dat;
      for (int i = 1; i < DAT_DLY; i++) dat_dly[i] <= dat_dly[i-1];
    end
  end

  assign cnt_inc = cnt + W_N'(1);
  assign drop    = we_q & fifo_full & ~(rd_en & ~fifo_empty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      cnt   <= '0;
      n_lat <= '0;
      we_q  <= 1'b0;
      wd_q  <= '0;
    end else begin
      we_q <= 1'b0;
      if (drop) ovf <= 1'b1;
      if (!cap_en) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state <= S_ARMED;
            busy  <= 1'b1;
            n_lat <= n_smp;
            cnt   <= '0;
          end
          S_ARMED: begin
            if (edge_q) state <= S_RUN;
          end
          S_RUN: begin
            if (edge_q) begin
              we_q <= 1'b1;
              wd_q <= dat_dly[DAT_DLY-1];
              cnt  <= cnt_inc;
              if (n_lat != '0 && cnt_inc == n_lat) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
      // Flush wins over any edge or write in flight this cycle.
      if (cap_clr) begin
        cnt  <= '0;
        done <= 1'b0;
        ovf  <= 1'b0;
        we_q <= 1'b0;
      end
    end
  end

  capture_fifo #(
    .AW    (AW),
    .W_DAT (W_DAT)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (cap_clr),
    .we    (we_q),
    .wd    (wd_q),
    .re    (rd_en),
    .rd    (rd_dat),
    .rv    (rd_vld),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
